// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter FSM states and the memory-mapped I/O address map
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_e;
  localparam int unsigned RO_BTN = 503;
  localparam int unsigned RO_SW_LO = 504;
  localparam int unsigned RO_SW_HI = 505;
  localparam int unsigned LED_LO = 506;
  localparam int unsigned LED_HI = 507;
  localparam int unsigned DIG_LO = 508;
  localparam int unsigned DIG_HI = 511;
  function automatic logic is_ro(input int unsigned a);
    return a >= RO_BTN && a <= RO_SW_HI;
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way round-robin pick; on a tie the port not granted last wins
module mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);
  always_comb begin
    valid = |req;
    gnt = &req ? ~last : req[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port memory with read-only MMIO
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_rw,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_err,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  arb_state_e        state_q;
  logic [1:0]        ack_q, err_q;
  logic              last_q, win_q, blk_q, mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              gnt, gnt_v, sel_rw, sel_ro;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_pick u_pick (
    .req  ({p1_req, p0_req}),
    .last (last_q),
    .gnt  (gnt),
    .valid(gnt_v)
  );

  always_comb begin
    sel_rw = gnt ? p1_rw : p0_rw;
    sel_addr = gnt ? p1_addr : p0_addr;
    sel_wdata = gnt ? p1_wdata : p0_wdata;
    sel_ro = is_ro(32'(sel_addr));
  end

  // Blocked writes still go through ACCESS/RESP so latency stays fixed; only mem_rw is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= 2'b00;
      err_q <= 2'b00;
      last_q <= 1'b1;
      win_q <= 1'b0;
      blk_q <= 1'b0;
      mem_rw_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_v) begin
            state_q <= ACCESS;
            win_q <= gnt;
            last_q <= gnt;
            mem_rw_q <= sel_rw & ~sel_ro;
            blk_q <= sel_rw & sel_ro;
            mem_addr_q <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          mem_rw_q <= 1'b0;
          ack_q <= win_q ? 2'b10 : 2'b01;
          err_q <= blk_q ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        end
        default: begin
          state_q <= IDLE;
          ack_q <= 2'b00;
          err_q <= 2'b00;
        end
      endcase
    end
  end

  // Gating with rst keeps an access cut short by reset from ever being acknowledged.
  always_comb begin
    p0_ack = ack_q[0] & ~rst;
    p1_ack = ack_q[1] & ~rst;
    p0_err = err_q[0] & ~rst;
    p1_err = err_q[1] & ~rst;
    rdata = state_q == RESP ? mem_rdata : '0;
    busy = state_q != IDLE;
    mem_rw = mem_rw_q;
    mem_addr = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner sequences and a transaction-level random model for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic p0_req = 1'b0, p1_req = 1'b0, p0_rw = 1'b0, p1_rw = 1'b0;
  logic [8:0] p0_addr = '0, p1_addr = '0;
  logic [7:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ack, p1_ack, p0_err, p1_err, mem_rw, busy;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [8:0] mem_addr;
  logic [7:0] mem [0:511];
  logic [7:0] ref_mem [0:511];
  logic mem_load = 1'b1;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit p;
    bit w;
    logic [8:0] a;
    logic [7:0] d;
    bit e;
    logic [7:0] rd;
  } vec_t;
  vec_t vt [15];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_rw(p0_rw), .p1_rw(p1_rw),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_err(p0_err), .p1_err(p1_err),
    .rdata(rdata), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
    end else if (mem_rw) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_port(input bit p, input logic r, input logic w, input logic [8:0] a, input logic [7:0] d);
    if (p) begin
      p1_req = r; p1_rw = w; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = r; p0_rw = w; p0_addr = a; p0_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_rw", 32'(mem_rw), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_ack", 32'({p1_ack, p0_ack}), 0);
    chk("rst_err", 32'({p1_err, p0_err}), 0);
  endtask

  task automatic await_ack(output int dly, output logic [1:0] who);
    dly = -1;
    who = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        dly = k;
        who = {p1_ack, p0_ack};
        break;
      end
    end
  endtask

  task automatic xact(input bit p, input bit w, input logic [8:0] a, input logic [7:0] d, input bit e, input logic [7:0] rd);
    int oh;
    oh = p ? 2 : 1;
    @(posedge clk); #1;
    set_port(p, 1'b1, w, a, d);
    @(negedge clk);
    chk("x_idle_ack", 32'({p1_ack, p0_ack}), 0);
    chk("x_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("x_acc_rw", 32'(mem_rw), 32'(w && !e));
    chk("x_acc_addr", 32'(mem_addr), 32'(a));
    chk("x_acc_busy", 32'(busy), 1);
    chk("x_acc_ack", 32'({p1_ack, p0_ack}), 0);
    @(negedge clk);
    chk("x_ack", 32'({p1_ack, p0_ack}), oh);
    chk("x_err", 32'({p1_err, p0_err}), e ? oh : 0);
    if (!w) chk("x_rdata", 32'(rdata), 32'(rd));
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, 9'd0, 8'd0);
    if (w && !e) ref_mem[a] = d;
  endtask

  bit rq [2], rwv [2];
  logic [8:0] adv [2];
  logic [7:0] wdv [2];

  initial begin
    int d, g;
    logic [1:0] w, ack_prev, exp_ack;
    bit pend, gp, g_rw, g_err, last_m;
    logic [8:0] g_a;
    logic [7:0] g_rd;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i);
    vt[0]  = '{1'b0, 1'b1, 9'd506, 8'h5A, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 9'd506, 8'h00, 1'b0, 8'h5A};
    vt[2]  = '{1'b1, 1'b1, 9'd504, 8'hFF, 1'b1, 8'h00};
    vt[3]  = '{1'b1, 1'b0, 9'd504, 8'h00, 1'b0, 8'hF8};
    vt[4]  = '{1'b0, 1'b1, 9'd503, 8'h00, 1'b1, 8'h00};
    vt[5]  = '{1'b0, 1'b0, 9'd503, 8'h00, 1'b0, 8'hF7};
    vt[6]  = '{1'b1, 1'b1, 9'd505, 8'h12, 1'b1, 8'h00};
    vt[7]  = '{1'b1, 1'b0, 9'd505, 8'h00, 1'b0, 8'hF9};
    vt[8]  = '{1'b1, 1'b1, 9'd507, 8'h77, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 1'b0, 9'd507, 8'h00, 1'b0, 8'h77};
    vt[10] = '{1'b0, 1'b1, 9'd502, 8'h01, 1'b0, 8'h00};
    vt[11] = '{1'b1, 1'b0, 9'd502, 8'h00, 1'b0, 8'h01};
    vt[12] = '{1'b1, 1'b1, 9'd508, 8'hAB, 1'b0, 8'h00};
    vt[13] = '{1'b0, 1'b0, 9'd508, 8'h00, 1'b0, 8'hAB};
    vt[14] = '{1'b0, 1'b0, 9'd100, 8'h00, 1'b0, 8'h64};
    @(posedge clk); #1;
    mem_load = 1'b0;
    do_reset();
    foreach (vt[i]) xact(vt[i].p, vt[i].w, vt[i].a, vt[i].d, vt[i].e, vt[i].rd);

    // tie right after reset: port 0 first, then port 1, then port 0 again
    do_reset();
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd506, 8'd0);
    set_port(1'b1, 1'b1, 1'b0, 9'd507, 8'd0);
    await_ack(d, w);
    chk("tie1_dly", 32'(d), 2);
    chk("tie1_who", 32'(w), 1);
    chk("tie1_rdata", 32'(rdata), 32'h5A);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    await_ack(d, w);
    chk("tie2_dly", 32'(d), 2);
    chk("tie2_who", 32'(w), 2);
    chk("tie2_rdata", 32'(rdata), 32'h77);
    @(posedge clk); #1;
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd506, 8'd0);
    set_port(1'b1, 1'b1, 1'b0, 9'd507, 8'd0);
    await_ack(d, w);
    chk("tie3_dly", 32'(d), 2);
    chk("tie3_who", 32'(w), 1);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    await_ack(d, w);
    chk("tie4_who", 32'(w), 2);
    @(posedge clk); #1;
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);

    // port 0 held high for three back-to-back accesses
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd502, 8'd0);
    for (int i = 0; i < 3; i++) begin
      await_ack(d, w);
      chk("hold_dly", 32'(d), 2);
      chk("hold_who", 32'(w), 1);
      chk("hold_rdata", 32'(rdata), 32'h01);
      @(posedge clk); #1;
      if (i == 2) set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    end

    // reset during RESP swallows the ack
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd506, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_busy_acc", 32'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_ack", 32'({p1_ack, p0_ack}), 0);
    chk("rr_err", 32'({p1_err, p0_err}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    chk("rr_busy_after", 32'(busy), 0);
    chk("rr_ack_after", 32'({p1_ack, p0_ack}), 0);

    // reset during ACCESS of a write: memory still takes it, no ack
    @(posedge clk); #1;
    set_port(1'b1, 1'b1, 1'b1, 9'd509, 8'h3C);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ra_mem_rw", 32'(mem_rw), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    chk("ra_ack", 32'({p1_ack, p0_ack}), 0);
    chk("ra_busy", 32'(busy), 0);
    ref_mem[509] = 8'h3C;
    xact(1'b0, 1'b0, 9'd509, 8'h00, 1'b0, 8'h3C);

    // both ports held for ten accesses: strict alternation
    do_reset();
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd506, 8'd0);
    set_port(1'b1, 1'b1, 1'b0, 9'd507, 8'd0);
    for (int i = 0; i < 10; i++) begin
      await_ack(d, w);
      chk("alt_dly", 32'(d), 2);
      chk("alt_who", 32'(w), (i % 2) ? 2 : 1);
      @(posedge clk); #1;
    end
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);

    // random traffic against a transaction-level model
    do_reset();
    last_m = 1'b1;
    pend = 1'b0;
    g = -10;
    gp = 1'b0;
    g_rw = 1'b0;
    g_err = 1'b0;
    g_a = '0;
    g_rd = '0;
    ack_prev = 2'b00;
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (ack_prev[p] || !rq[p]) begin
          rq[p] = $urandom_range(0, 1) == 1;
          rwv[p] = $urandom_range(0, 1) == 1;
          adv[p] = $urandom_range(0, 1) == 1 ? 9'($urandom_range(500, 511)) : 9'($urandom_range(0, 511));
          wdv[p] = 8'($urandom);
        end
      end
      set_port(1'b0, rq[0], rwv[0], adv[0], wdv[0]);
      set_port(1'b1, rq[1], rwv[1], adv[1], wdv[1]);
      @(negedge clk);
      exp_ack = (pend && c == g + 2) ? (gp ? 2'b10 : 2'b01) : 2'b00;
      chk("r_ack", 32'({p1_ack, p0_ack}), 32'(exp_ack));
      chk("r_err", 32'({p1_err, p0_err}), 32'(g_err ? exp_ack : 2'b00));
      chk("r_busy", 32'(busy), 32'(pend && c > g));
      chk("r_mem_rw", 32'(mem_rw), 32'(pend && c == g + 1 && g_rw && !g_err));
      if (pend && c == g + 1) chk("r_mem_addr", 32'(mem_addr), 32'(g_a));
      if (exp_ack != 2'b00 && !g_rw) chk("r_rdata", 32'(rdata), 32'(g_rd));
      ack_prev = {p1_ack, p0_ack};
      if (pend && c == g + 2) pend = 1'b0;
      if (!pend && c >= g + 3 && (rq[0] || rq[1])) begin
        gp = (rq[0] && rq[1]) ? !last_m : rq[1];
        last_m = gp;
        g = c;
        pend = 1'b1;
        g_rw = rwv[gp];
        g_a = adv[gp];
        g_err = g_rw && g_a >= 9'd503 && g_a <= 9'd505;
        g_rd = ref_mem[g_a];
        if (g_rw && !g_err) ref_mem[g_a] = wdv[gp];
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
